// File: rtl/lcd_status_reader.sv
// HD44780 status read (BF + AC) over the 8-bit LCD bus, with optional busy-flag polling.
// Define LCD_RD_TIMEOUT_EN to bound polling to MAX_POLLS reads and enable the sticky timeout flag.
module lcd_status_reader #(
  parameter int T_AS      = 2,
  parameter int T_EN_HI   = 4,
  parameter int T_EN_LO   = 4,
  parameter int MAX_POLLS = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  input  logic       poll,
  input  logic [7:0] lcd_data_in,
  output logic       rs,
  output logic       rw,
  output logic       en,
  output logic       data_oe,
  output logic       ready,
  output logic       valid,
  output logic       busy,
  output logic [6:0] addr,
  output logic       timeout
);

  if (T_AS < 1 || T_AS > 255 || T_EN_HI < 1 || T_EN_HI > 255 ||
      T_EN_LO < 1 || T_EN_LO > 255 || MAX_POLLS < 1 || MAX_POLLS > 255) begin : g_param_check
    $error("lcd_status_reader: timing/poll parameters must be within 1..255");
  end

  localparam logic [7:0] AS_LD = 8'(T_AS - 1);
  localparam logic [7:0] HI_LD = 8'(T_EN_HI - 1);
  localparam logic [7:0] LO_LD = 8'(T_EN_LO - 1);

  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, EN_LO, DONE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       poll_q;
  logic [7:0] sample;
  logic       cnt_done;
  logic       poll_limit;

  assign cnt_done = (cnt == 8'd0);
  assign rs       = 1'b0;
  assign data_oe  = 1'b0;

`ifdef LCD_RD_TIMEOUT_EN
  localparam logic [7:0] MAX_LD = 8'(MAX_POLLS);
  logic [7:0] poll_cnt;
  logic       timeout_q;
  assign poll_limit = ((poll_cnt + 8'd1) == MAX_LD);
  assign timeout    = timeout_q;
`else
  assign poll_limit = 1'b0;
  assign timeout    = 1'b0;
`endif

  // Bus capture: taken on the last EN-high cycle while the LCD still drives the bus
  always_ff @(posedge clk) begin
    if (state == EN_HI && cnt_done) sample <= lcd_data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 8'd0;
      poll_q <= 1'b0;
      rw     <= 1'b0;
      en     <= 1'b0;
      ready  <= 1'b1;
      valid  <= 1'b0;
      busy   <= 1'b0;
      addr   <= 7'd0;
`ifdef LCD_RD_TIMEOUT_EN
      poll_cnt  <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            poll_q <= poll;
            rw     <= 1'b1;
            ready  <= 1'b0;
            cnt    <= AS_LD;
            state  <= SETUP;
`ifdef LCD_RD_TIMEOUT_EN
            poll_cnt  <= 8'd0;
            timeout_q <= 1'b0;
`endif
          end
        end
        SETUP: begin
          if (cnt_done) begin
            en    <= 1'b1;
            cnt   <= HI_LD;
            state <= EN_HI;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        EN_HI: begin
          if (cnt_done) begin
            en    <= 1'b0;
            cnt   <= LO_LD;
            state <= EN_LO;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        EN_LO: begin
          if (cnt_done) begin
`ifdef LCD_RD_TIMEOUT_EN
            poll_cnt <= poll_cnt + 8'd1;
            if (poll_q && sample[7] && poll_limit) timeout_q <= 1'b1;
`endif
            // Another read only while polling and the LCD still reports busy
            if (poll_q && sample[7] && !poll_limit) begin
              cnt   <= AS_LD;
              state <= SETUP;
            end else begin
              cnt   <= 8'd0;
              state <= DONE;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          busy  <= sample[7];
          addr  <= sample[6:0];
          valid <= 1'b1;
          rw    <= 1'b0;
          ready <= 1'b1;
          cnt   <= 8'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_status_reader.sv
// Directed bench for lcd_status_reader: reset, single read, polling, ignored req,
// timeout (or unlimited polling without LCD_RD_TIMEOUT_EN) and back-to-back reads.
module tb_lcd_status_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       poll = 1'b0;
  logic [7:0] lcd_data_in = 8'h00;
  logic       rs, rw, en, data_oe, ready, valid, busy, timeout;
  logic [6:0] addr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcd_status_reader #(.T_AS(2), .T_EN_HI(4), .T_EN_LO(4), .MAX_POLLS(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .poll(poll), .lcd_data_in(lcd_data_in),
    .rs(rs), .rw(rw), .en(en), .data_oe(data_oe), .ready(ready), .valid(valid),
    .busy(busy), .addr(addr), .timeout(timeout)
  );

  // Issues one request and observes the bus until valid (or the budget runs out).
  // After script_n EN pulses have completed the bus switches to 8'h12.
  task automatic run_read(input logic p, input int budget, input int script_n,
                          output int lat, output int pulses, output int min_hi,
                          output int max_hi, output int min_gap, output int rw_hi,
                          output int ready_hi, output int oe_hi, output int ba_chg);
    logic       prev;
    int         run, gap;
    logic [7:0] ba0;
    lat = -1; pulses = 0; min_hi = 999; max_hi = 0; min_gap = 999;
    rw_hi = 0; ready_hi = 0; oe_hi = 0; ba_chg = 0; run = 0; gap = 0;
    ba0 = {busy, addr};
    @(negedge clk); req = 1'b1; poll = p;
    @(posedge clk); #1; req = 1'b0; poll = 1'b0;
    prev = en;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (en) begin
        if (!prev) begin
          pulses++;
          if (pulses > 1 && gap < min_gap) min_gap = gap;
        end
        run++;
      end else begin
        if (prev) begin
          if (run < min_hi) min_hi = run;
          if (run > max_hi) max_hi = run;
          run = 0;
          gap = 0;
        end
        gap++;
      end
      prev = en;
      rw_hi += int'(rw);
      ready_hi += int'(ready);
      oe_hi += int'(data_oe | rs);
      if (script_n > 0 && pulses == script_n && !en) lcd_data_in = 8'h12;
      if (valid) begin
        lat = n;
        break;
      end
      if ({busy, addr} != ba0) ba_chg++;
    end
  endtask

  task automatic test_reset();
    int lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac;
    int seen_en, en_cnt, v_cnt;
    repeat (2) @(negedge clk);
    checks++; if ({rs, rw, en, data_oe, valid, busy, timeout} !== 7'b0) begin errors++;
      $display("FAIL reset_outputs: got %b required 0000000", {rs, rw, en, data_oe, valid, busy, timeout}); end
    checks++; if (ready !== 1'b1 || addr !== 7'h00) begin errors++;
      $display("FAIL reset_ready_addr: got ready=%b addr=%h required ready=1 addr=00", ready, addr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (ready !== 1'b1 || en !== 1'b0) begin errors++;
      $display("FAIL reset_release: got ready=%b en=%b required ready=1 en=0", ready, en); end
    // Load busy/addr with a real read, then interrupt a second read mid-pulse
    lcd_data_in = 8'h45;
    run_read(1'b0, 50, 0, lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac);
    lcd_data_in = 8'hFF;
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    seen_en = 0;
    for (int n = 0; n < 10 && !seen_en; n++) begin
      @(posedge clk); #1;
      if (en) seen_en = 1;
    end
    checks++; if (seen_en !== 1) begin errors++;
      $display("FAIL reset_en_wait: got en_seen=%0d required 1", seen_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (en !== 1'b0 || rw !== 1'b0) begin errors++;
      $display("FAIL reset_async_en: got en=%b rw=%b required 0 0", en, rw); end
    checks++; if (busy !== 1'b0 || addr !== 7'h00 || ready !== 1'b1 || valid !== 1'b0) begin errors++;
      $display("FAIL reset_async_state: got busy=%b addr=%h ready=%b valid=%b required 0 00 1 0",
               busy, addr, ready, valid); end
    @(negedge clk); rst_n = 1'b1;
    en_cnt = 0; v_cnt = 0;
    repeat (15) begin
      @(posedge clk); #1;
      en_cnt += int'(en);
      v_cnt += int'(valid);
    end
    checks++; if (en_cnt !== 0 || v_cnt !== 0 || ready !== 1'b1) begin errors++;
      $display("FAIL reset_read_lost: got en_cycles=%0d valids=%0d ready=%b required 0 0 1",
               en_cnt, v_cnt, ready); end
  endtask

  task automatic test_single();
    int lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac;
    lcd_data_in = 8'h45;
    run_read(1'b0, 50, 0, lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac);
    checks++; if (lat !== 11) begin errors++;
      $display("FAIL single_latency: got %0d required 11", lat); end
    checks++; if (pl !== 1 || mnh !== 4 || mxh !== 4) begin errors++;
      $display("FAIL single_en: got pulses=%0d hi=%0d..%0d required 1 4..4", pl, mnh, mxh); end
    checks++; if (busy !== 1'b0 || addr !== 7'h45) begin errors++;
      $display("FAIL single_data: got busy=%b addr=%h required 0 45", busy, addr); end
    checks++; if (rwh !== 10 || rdh !== 1 || oeh !== 0 || rw !== 1'b0) begin errors++;
      $display("FAIL single_ctrl: got rw_hi=%0d ready_hi=%0d oe=%0d rw=%b required 10 1 0 0",
               rwh, rdh, oeh, rw); end
    @(posedge clk); #1;
    checks++; if (valid !== 1'b0 || ready !== 1'b1) begin errors++;
      $display("FAIL single_valid_pulse: got valid=%b ready=%b required 0 1", valid, ready); end
  endtask

  task automatic test_poll();
    int lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac;
    lcd_data_in = 8'hC0;
    run_read(1'b1, 100, 3, lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac);
    checks++; if (lat !== 41 || pl !== 4) begin errors++;
      $display("FAIL poll_timing: got lat=%0d pulses=%0d required 41 4", lat, pl); end
    checks++; if (mnh !== 4 || mxh !== 4 || mg !== 6 || rwh !== 40) begin errors++;
      $display("FAIL poll_shape: got hi=%0d..%0d gap=%0d rw_hi=%0d required 4..4 6 40",
               mnh, mxh, mg, rwh); end
    checks++; if (busy !== 1'b0 || addr !== 7'h12 || bac !== 0) begin errors++;
      $display("FAIL poll_data: got busy=%b addr=%h early_changes=%0d required 0 12 0", busy, addr, bac); end
  endtask

  task automatic test_ignored_req();
    logic prev;
    int rises, vals, acc;
    lcd_data_in = 8'h33;
    rises = 0; vals = 0; acc = 0;
    prev = en;
    for (int n = 0; n < 45; n++) begin
      @(negedge clk);
      req = (n < 20) && (n % 2 == 0);
      if (req && ready) acc++;
      @(posedge clk); #1;
      if (en && !prev) rises++;
      prev = en;
      vals += int'(valid);
    end
    req = 1'b0;
    checks++; if (rises !== 2 || vals !== 2) begin errors++;
      $display("FAIL ignored_req: got en_pulses=%0d valids=%0d required 2 2", rises, vals); end
    checks++; if (acc !== 2 || addr !== 7'h33) begin errors++;
      $display("FAIL ignored_req_accept: got accepted=%0d addr=%h required 2 33", acc, addr); end
  endtask

  task automatic test_timeout();
    int lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac;
    lcd_data_in = 8'h80;
`ifdef LCD_RD_TIMEOUT_EN
    run_read(1'b1, 200, 0, lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac);
    checks++; if (lat !== 31 || pl !== 3) begin errors++;
      $display("FAIL timeout_timing: got lat=%0d pulses=%0d required 31 3", lat, pl); end
    checks++; if (busy !== 1'b1 || timeout !== 1'b1) begin errors++;
      $display("FAIL timeout_flag: got busy=%b timeout=%b required 1 1", busy, timeout); end
    repeat (5) @(posedge clk); #1;
    checks++; if (timeout !== 1'b1) begin errors++;
      $display("FAIL timeout_held: got %b required 1", timeout); end
    lcd_data_in = 8'h05;
    run_read(1'b0, 50, 0, lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac);
    checks++; if (timeout !== 1'b0 || busy !== 1'b0 || addr !== 7'h05) begin errors++;
      $display("FAIL timeout_clear: got timeout=%b busy=%b addr=%h required 0 0 05", timeout, busy, addr); end
`else
    run_read(1'b1, 200, 5, lat, pl, mnh, mxh, mg, rwh, rdh, oeh, bac);
    checks++; if (lat !== 61 || pl !== 6) begin errors++;
      $display("FAIL nolimit_timing: got lat=%0d pulses=%0d required 61 6", lat, pl); end
    checks++; if (timeout !== 1'b0 || busy !== 1'b0 || addr !== 7'h12) begin errors++;
      $display("FAIL nolimit_data: got timeout=%b busy=%b addr=%h required 0 0 12", timeout, busy, addr); end
`endif
  endtask

  task automatic test_back_to_back();
    logic prev;
    int vals, rises, gap, min_gap, max_gap;
    int vcyc[3];
    lcd_data_in = 8'h07;
    vals = 0; rises = 0; gap = 0; min_gap = 999; max_gap = 0;
    vcyc[0] = -1; vcyc[1] = -1; vcyc[2] = -1;
    @(negedge clk); req = 1'b1;
    prev = en;
    for (int n = 0; n < 70; n++) begin
      @(posedge clk); #1;
      if (en && !prev) begin
        rises++;
        if (rises > 1) begin
          if (gap < min_gap) min_gap = gap;
          if (gap > max_gap) max_gap = gap;
        end
      end
      if (!en) gap++; else gap = 0;
      prev = en;
      if (valid) begin
        if (vals < 3) vcyc[vals] = n;
        vals++;
        if (vals == 3) req = 1'b0;
      end
    end
    req = 1'b0;
    checks++; if (vals !== 3 || rises !== 3) begin errors++;
      $display("FAIL b2b_count: got valids=%0d pulses=%0d required 3 3", vals, rises); end
    checks++; if (vcyc[0] !== 11 || vcyc[1] !== 23 || vcyc[2] !== 35) begin errors++;
      $display("FAIL b2b_valid_cycles: got %0d %0d %0d required 11 23 35", vcyc[0], vcyc[1], vcyc[2]); end
    checks++; if (min_gap !== 8 || max_gap !== 8) begin errors++;
      $display("FAIL b2b_en_gap: got %0d..%0d required 8..8", min_gap, max_gap); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_poll();
    test_ignored_req();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
